alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 clk  input  1  — sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  — asynchronous, active-low reset.
REQ-003 in_valid  input  1  — upstream instruction valid.
REQ-004 in_ready  output  1  — stage can accept an instruction this cycle.
REQ-005 instr  input  32  — RV32I instruction word.
REQ-006 pc  input  32  — address of instr.
REQ-007 rs1_data, rs2_data  input  32 each  — register-file read data for instr.
REQ-008 flush  input  1  — synchronous kill of stage contents and of this cycle's input.
REQ-009 out_valid  output  1  — registered issue packet valid.
REQ-010 out_ready  input  1  — downstream ALU stage accepts the packet.
REQ-011 op_a, op_b  output  32 each  — registered ALU operands.
REQ-012 alu_ctrl  output  4  — ALU op code: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLTU=0110, SLL=0111, SRL=1000, SRA=1001.
REQ-013 rd_addr  output  5  — destination register (instr[11:7]).
REQ-014 reg_write  output  1  — writeback enable.
REQ-015 illegal  output  1  — instruction not supported by this stage.

Function
REQ-016 The stage SHALL be a single-entry pipeline register; in_ready = !flush && (!out_valid || out_ready).
REQ-017 Accept = in_valid && in_ready; on accept, all packet outputs SHALL load the decoded instr and out_valid SHALL be 1 the next cycle (latency 1).
REQ-018 If out_valid && !out_ready, all packet outputs SHALL hold unchanged.
REQ-019 If out_valid && out_ready && !accept, out_valid SHALL drop to 0; simultaneous drain and accept SHALL keep out_valid=1 with the new packet.
REQ-020 flush SHALL take priority: next cycle out_valid=0 and no input captured, regardless of in_valid/out_ready.
REQ-021 OP (0110011): op_a=rs1_data, op_b=rs2_data; funct3 000/funct7 0000000 ADD, 000/0100000 SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101/0000000 SRL, 101/0100000 SRA, 110 OR, 111 AND; funct7 other than 0000000 (or 0100000 for 000/101) SHALL set illegal.
REQ-022 OP-IMM (0010011): op_a=rs1_data, op_b=sign-extended instr[31:20]; funct3 mapping as OP without SUB; for 001/101 op_b={27'b0, instr[24:20]}, funct7 0000000 selects SLL/SRL, 0100000 (101 only) selects SRA, anything else illegal.
REQ-023 LUI (0110111): op_a=0, op_b={instr[31:12],12'b0}, alu_ctrl=ADD.
REQ-024 AUIPC (0010111): op_a=pc, op_b={instr[31:12],12'b0}, alu_ctrl=ADD.
REQ-025 Any other opcode, or illegal funct combination: illegal=1, reg_write=0, op_a=op_b=0, alu_ctrl=ADD; packet still issued with out_valid=1.
REQ-026 reg_write SHALL be 1 only for a legal instruction with rd_addr != 0.
REQ-027 Decode SHALL be purely from instr/pc/rs data in the accept cycle; no state beyond the output register and out_valid.

Reset
REQ-028 On rst_n=0, immediately and asynchronously: out_valid=0, op_a=0, op_b=0, alu_ctrl=0000, rd_addr=0, reg_write=0, illegal=0.
REQ-029 Reset asserted mid-handshake SHALL discard any held packet; first accept allowed on the first rising edge with rst_n=1.

Verification
REQ-030 ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, op_a=5, op_b=7, alu_ctrl=0000, rd_addr=3, reg_write=1, illegal=0.
REQ-031 SRAI x5,x6,4 (0x40435293), rs1=0x80000000 -> op_a=0x80000000, op_b=0x00000004, alu_ctrl=1001; ADDI x1,x0,-1 (0xFFF00093) -> op_b=0xFFFFFFFF, alu_ctrl=0000.
REQ-032 LUI x1,0x12345 (0x123450B7) -> op_a=0, op_b=0x12345000; AUIPC with pc=0x100, instr 0x00001097 -> op_a=0x100, op_b=0x1000.
REQ-033 Backpressure: packet held with out_ready=0 for 3 cycles while second instr presented -> in_ready=0, outputs stable 3 cycles; out_ready=1 -> second packet visible next cycle, no loss or duplication.
REQ-034 flush=1 with out_valid=1 and in_valid=1 -> in_ready=0, next cycle out_valid=0; instr 0x00000000 -> illegal=1, reg_write=0; ADDI x0 (0x00100013) -> reg_write=0, illegal=0.
REQ-035 rst_n pulled low between clock edges while out_valid=1 -> out_valid=0 without waiting for clk.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: single-entry issue register for the integer ALU.
// Decodes RV32I OP, OP-IMM, LUI and AUIPC into ALU operands and an op code.
// Anything else is issued as an illegal, non-writing packet so the
// downstream stage can raise the exception in order.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [3:0]  alu_ctrl,
  output logic [4:0]  rd_addr,
  output logic        reg_write,
  output logic        illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic signed [31:0] imm_i;
  logic [31:0]        imm_u;
  logic [31:0]        dec_a;
  logic [31:0]        dec_b;
  logic [3:0]         dec_ctrl;
  logic               dec_ill;
  logic [4:0]         dec_rd;
  logic               accept;
  // rs1 field is consumed upstream by the register file read
  logic               unused_rs1_field;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = 32'(signed'(instr[31:20]));
  assign imm_u  = {instr[31:12], 12'b0};
  assign dec_rd = instr[11:7];
  assign unused_rs1_field = ^instr[19:15];

  // Flush blocks capture; otherwise accept when empty or draining this cycle
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Combinational decode of the presented instruction
  always_comb begin
    dec_a    = 32'd0;
    dec_b    = 32'd0;
    dec_ctrl = ALU_ADD;
    dec_ill  = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a = rs1_data;
        dec_b = rs2_data;
        case (funct3)
          3'b000: begin
            if (funct7 == F7_ALT) dec_ctrl = ALU_SUB;
            else if (funct7 != F7_BASE) dec_ill = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_ALT) dec_ctrl = ALU_SRA;
            else if (funct7 == F7_BASE) dec_ctrl = ALU_SRL;
            else dec_ill = 1'b1;
          end
          default: begin
            if (funct7 != F7_BASE) dec_ill = 1'b1;
            case (funct3)
              3'b001:  dec_ctrl = ALU_SLL;
              3'b010:  dec_ctrl = ALU_SLT;
              3'b011:  dec_ctrl = ALU_SLTU;
              3'b100:  dec_ctrl = ALU_XOR;
              3'b110:  dec_ctrl = ALU_OR;
              default: dec_ctrl = ALU_AND;
            endcase
          end
        endcase
      end
      OPC_OP_IMM: begin
        dec_a = rs1_data;
        dec_b = imm_i;
        case (funct3)
          3'b000: dec_ctrl = ALU_ADD;
          3'b010: dec_ctrl = ALU_SLT;
          3'b011: dec_ctrl = ALU_SLTU;
          3'b100: dec_ctrl = ALU_XOR;
          3'b110: dec_ctrl = ALU_OR;
          3'b111: dec_ctrl = ALU_AND;
          3'b001: begin
            dec_b    = {27'b0, instr[24:20]};
            dec_ctrl = ALU_SLL;
            if (funct7 != F7_BASE) dec_ill = 1'b1;
          end
          default: begin
            dec_b = {27'b0, instr[24:20]};
            if (funct7 == F7_BASE) dec_ctrl = ALU_SRL;
            else if (funct7 == F7_ALT) dec_ctrl = ALU_SRA;
            else dec_ill = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        dec_b = imm_u;
      end
      OPC_AUIPC: begin
        dec_a = pc;
        dec_b = imm_u;
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal packets carry neutral operands so nothing downstream acts on them
    if (dec_ill) begin
      dec_a    = 32'd0;
      dec_b    = 32'd0;
      dec_ctrl = ALU_ADD;
    end
  end

  // Issue register: flush wins, then capture, then drain; holds under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      alu_ctrl  <= ALU_ADD;
      rd_addr   <= 5'd0;
      reg_write <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      op_a      <= dec_a;
      op_b      <= dec_b;
      alu_ctrl  <= dec_ctrl;
      rd_addr   <= dec_rd;
      reg_write <= !dec_ill && (dec_rd != 5'd0);
      illegal   <= dec_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table plus handshake,
// flush and asynchronous reset sequences.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } vec_t;

  vec_t v[16];

  alu_issue_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .alu_ctrl  (alu_ctrl),
    .rd_addr   (rd_addr),
    .reg_write (reg_write),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_pkt(input string tag, input vec_t e);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".op_a"}, op_a, e.a);
    chk({tag, ".op_b"}, op_b, e.b);
    chk({tag, ".alu_ctrl"}, {28'd0, alu_ctrl}, {28'd0, e.ctrl});
    chk({tag, ".rd_addr"}, {27'd0, rd_addr}, {27'd0, e.rd});
    chk({tag, ".reg_write"}, {31'd0, reg_write}, {31'd0, e.rw});
    chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, e.ill});
  endtask

  task automatic drive(input vec_t e);
    instr    = e.instr;
    pc       = e.pc;
    rs1_data = e.rs1;
    rs2_data = e.rs2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        instr          pc             rs1            rs2            op_a           op_b           ctrl  rd     rw    ill
    v[0]  = '{32'h002081B3, 32'h00000000, 32'h00000005, 32'h00000007, 32'h00000005, 32'h00000007, 4'h0, 5'd3, 1'b1, 1'b0}; // ADD
    v[1]  = '{32'h40435293, 32'h00000000, 32'h80000000, 32'h00000000, 32'h80000000, 32'h00000004, 4'h9, 5'd5, 1'b1, 1'b0}; // SRAI
    v[2]  = '{32'hFFF00093, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'h0, 5'd1, 1'b1, 1'b0}; // ADDI -1
    v[3]  = '{32'h123450B7, 32'h00000040, 32'h0000AAAA, 32'h0000BBBB, 32'h00000000, 32'h12345000, 4'h0, 5'd1, 1'b1, 1'b0}; // LUI
    v[4]  = '{32'h00001097, 32'h00000100, 32'h0000AAAA, 32'h0000BBBB, 32'h00000100, 32'h00001000, 4'h0, 5'd1, 1'b1, 1'b0}; // AUIPC
    v[5]  = '{32'h00000000, 32'h00000000, 32'h00000011, 32'h00000022, 32'h00000000, 32'h00000000, 4'h0, 5'd0, 1'b0, 1'b1}; // all-zero
    v[6]  = '{32'h00100013, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000001, 4'h0, 5'd0, 1'b0, 1'b0}; // ADDI x0
    v[7]  = '{32'h402081B3, 32'h00000000, 32'h00000009, 32'h00000004, 32'h00000009, 32'h00000004, 4'h1, 5'd3, 1'b1, 1'b0}; // SUB
    v[8]  = '{32'h0020B233, 32'h00000000, 32'h00000001, 32'h00000002, 32'h00000001, 32'h00000002, 4'h6, 5'd4, 1'b1, 1'b0}; // SLTU
    v[9]  = '{32'h022081B3, 32'h00000000, 32'h00000005, 32'h00000007, 32'h00000000, 32'h00000000, 4'h0, 5'd3, 1'b0, 1'b1}; // MUL (bad funct7)
    v[10] = '{32'h40431293, 32'h00000000, 32'h00000033, 32'h00000000, 32'h00000000, 32'h00000000, 4'h0, 5'd5, 1'b0, 1'b1}; // SLLI alt funct7
    v[11] = '{32'h00435293, 32'h00000000, 32'h000000F0, 32'h00000000, 32'h000000F0, 32'h00000004, 4'h8, 5'd5, 1'b1, 1'b0}; // SRLI
    v[12] = '{32'hFF00F393, 32'h00000000, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFF0, 4'h2, 5'd7, 1'b1, 1'b0}; // ANDI -16
    v[13] = '{32'h0041E133, 32'h00000000, 32'h0000000A, 32'h00000005, 32'h0000000A, 32'h00000005, 4'h3, 5'd2, 1'b1, 1'b0}; // OR
    v[14] = '{32'h403150B3, 32'h00000000, 32'hC0000000, 32'h00000003, 32'hC0000000, 32'h00000003, 4'h9, 5'd1, 1'b1, 1'b0}; // SRA
    v[15] = '{32'h00002083, 32'h00000000, 32'h00000010, 32'h00000000, 32'h00000000, 32'h00000000, 4'h0, 5'd1, 1'b0, 1'b1}; // LW

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    instr = 32'd0; pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;

    // Reset state
    #12;
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.op_a", op_a, 32'd0);
    chk("rst.op_b", op_b, 32'd0);
    chk("rst.alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("rst.rd_addr", {27'd0, rd_addr}, 32'd0);
    chk("rst.reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst.illegal", {31'd0, illegal}, 32'd0);
    rst_n = 1'b1;

    // Decode table, back-to-back with downstream always ready
    for (int i = 0; i < 16; i++) begin
      drive(v[i]);
      in_valid = 1'b1;
      #1;
      chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      chk_pkt($sformatf("vec%0d", i), v[i]);
    end
    in_valid = 1'b0;
    tick();
    chk("drain.out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: hold ADD for 3 cycles while SUB waits
    drive(v[0]); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    drive(v[7]); out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d.in_ready", c), {31'd0, in_ready}, 32'd0);
      tick();
      chk_pkt($sformatf("bp%0d", c), v[0]);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk_pkt("bp.second", v[7]);
    in_valid = 1'b0;
    tick();
    chk("bp.nodup.out_valid", {31'd0, out_valid}, 32'd0);

    // Flush with a held packet and a presented instruction
    drive(v[0]); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    drive(v[7]); out_ready = 1'b0; flush = 1'b1;
    #1;
    chk("flush.in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("flush.out_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("flush.nocapture", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset between edges discards a held packet
    drive(v[13]); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    chk_pkt("prerst", v[13]);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst.op_a", op_a, 32'd0);
    chk("arst.op_b", op_b, 32'd0);
    chk("arst.alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("arst.rd_addr", {27'd0, rd_addr}, 32'd0);
    chk("arst.reg_write", {31'd0, reg_write}, 32'd0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(v[1]); in_valid = 1'b1;
    tick();
    chk_pkt("postrst", v[1]);
    in_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
